line_buffer_sequencer: RTL and testbench
========================================

LINE_BUFFER_SEQUENCER -- requirements
Module: line_buffer_sequencer

Interface
REQ-001 The block SHALL have parameter HRES, default 1280, meaning active pixels per line.
REQ-002 The block SHALL have parameter VRES, default 720, meaning active lines per frame.
REQ-003 The block SHALL have parameter LB_LATENCY, default 2, meaning line-buffer data_valid delay in cycles.
REQ-004 The block SHALL have port clk_in  input  1  system clock, the only clock.
REQ-005 The block SHALL have port rst_in  input  1  reset, asynchronous and active-high.
REQ-006 The block SHALL have port pix_valid_in  input  1  upstream pixel valid.
REQ-007 The block SHALL have port pix_data_in  input  16  upstream pixel.
REQ-008 The block SHALL have port pix_sof_in  input  1  start-of-frame flag, qualified by pix_valid_in.
REQ-009 The block SHALL have port pix_ready_out  output  1  upstream ready.
REQ-010 The block SHALL have ports lb_hcount_out (11), lb_vcount_out (10), lb_pixel_out (16) and lb_valid_out (1), all outputs, driving the line buffer.
REQ-011 The block SHALL have port lb_valid_in  input  1  line buffer data_valid_out.
REQ-012 The block SHALL have port window_valid_out  output  1  3-line kernel window valid.
REQ-013 The block SHALL have port state_out  output  2  current FSM state encoding.
REQ-014 The block SHALL have port frame_done_out  output  1  one-cycle end-of-frame pulse.
REQ-015 The block SHALL have port err_sof_out  output  1  one-cycle pulse on a mid-frame SOF.

Function
REQ-016 The FSM SHALL have states IDLE=0, PRIME=1, RUN=2 and GAP=3.
REQ-017 A pixel transfer SHALL occur when pix_valid_in && pix_ready_out are both high.
REQ-018 pix_ready_out SHALL be 1 in IDLE/PRIME/RUN and 0 in GAP, decoded combinationally from the state register.
REQ-019 In IDLE, non-SOF transfers SHALL be dropped; an SOF transfer SHALL be forwarded as pixel (0,0) and move the FSM to PRIME.
REQ-020 Each forwarded transfer SHALL register lb_pixel_out, lb_hcount_out and lb_vcount_out, and pulse lb_valid_out for 1 cycle (latency 1).
REQ-021 hcount SHALL advance 0..HRES-1; at HRES-1 it SHALL wrap to 0, vcount SHALL increment, and the FSM SHALL enter GAP for exactly 1 cycle.
REQ-022 The primed-line counter SHALL saturate at 2; the FSM SHALL return from GAP to PRIME while primed<2, and to RUN otherwise.
REQ-023 The transfer of pixel (HRES-1, VRES-1) SHALL pulse frame_done_out in the following cycle, clear the counters, and move the FSM to IDLE (no GAP).
REQ-024 An SOF transfer outside IDLE SHALL pulse err_sof_out, restart at (0,0), clear primed, forward the pixel and set the FSM to PRIME.
REQ-025 SOF coincident with the end-of-line transfer SHALL follow REQ-024 and take precedence over GAP.
REQ-026 window_valid_out SHALL equal lb_valid_in AND the primed flag of the matching pixel, that flag being delayed LB_LATENCY cycles.
REQ-027 lb_vcount_out SHALL carry the raw line count; line-offset correction SHALL remain the line buffer's responsibility.

Reset
REQ-028 While rst_in is high, the FSM SHALL be in IDLE, the counters and primed SHALL be 0, and all outputs except pix_ready_out SHALL be 0 regardless of clock.
REQ-029 Reset asserted mid-frame SHALL discard the frame; after release, the block SHALL wait in IDLE for an SOF.

Configuration
REQ-030 With LB_SEQ_STATS_EN defined, the block SHALL add outputs frame_count_out (16, wrapping) and drop_count_out (16, saturating at 0xFFFF counting IDLE-dropped pixels), both reset to 0.
REQ-031 Without LB_SEQ_STATS_EN, those ports and counters SHALL be absent and the behaviour SHALL otherwise be identical.

Structure
REQ-032 Package lb_seq_pkg SHALL hold the seq_state_t enum, PIXEL_W=16 and KERNEL_LINES=3.
REQ-033 The primed-flag delay SHALL be a sub-module, lb_seq_delay (parameterised stages and width, async reset).

Verification
REQ-034 Reset: assert rst_in mid-line with no clock edge -> all outputs 0, state_out=0 immediately.
REQ-035 HRES=4, VRES=4, SOF at pixel 0 then a continuous stream -> lb_valid_out follows each transfer by 1 cycle, ready drops 1 cycle after each hcount=3, and frame_done pulses once after the 16th pixel.
REQ-036 Priming: window_valid_out stays 0 for lines 0-1 and rises at the first pixel of line 2, LB_LATENCY cycles after lb_valid_out.
REQ-037 Mid-frame SOF at (2,1) -> err_sof_out pulses, lb_hcount_out=0, lb_vcount_out=0, state_out=1.
REQ-038 5 non-SOF pixels in IDLE -> no lb_valid_out; with LB_SEQ_STATS_EN, drop_count_out=5.
REQ-039 Bubbles: random pix_valid_in gaps across a 4x4 frame -> exactly 16 lb_valid_out pulses in raster order, each with correct coordinates.

Source files
------------

// File: rtl/lb_seq_pkg.sv
// Shared types and constants for the line-buffer sequencer.
package lb_seq_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPrime = 2'd1,
    StRun   = 2'd2,
    StGap   = 2'd3
  } seq_state_t;

  localparam int unsigned PIXEL_W      = 16;
  localparam int unsigned KERNEL_LINES = 3;

endpackage

// File: rtl/lb_seq_delay.sv
// Fixed-length shift delay with asynchronous active-high reset.
module lb_seq_delay #(
  parameter int unsigned Stages = 2,
  parameter int unsigned Width  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Stages == 0) begin : g_bypass
    assign q_o = d_i;
  end else begin : g_pipe
    logic [Width-1:0] stage_q [Stages];
    logic [Width-1:0] stage_d [Stages];

    always_comb begin
      stage_d[0] = d_i;
      for (int unsigned i = 1; i < Stages; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < Stages; i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        stage_q <= stage_d;
      end
    end

    assign q_o = stage_q[Stages-1];
  end

endmodule

// File: rtl/line_buffer_sequencer.sv
// Raster sequencer feeding a 3-line buffer: tracks (h,v), primes lines, flags kernel validity.
// Optional statistics outputs are enabled by defining LB_SEQ_STATS_EN.
module line_buffer_sequencer
  import lb_seq_pkg::*;
#(
  parameter int unsigned HRES       = 1280,
  parameter int unsigned VRES       = 720,
  parameter int unsigned LB_LATENCY = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               pix_valid_in,
  input  logic [PIXEL_W-1:0] pix_data_in,
  input  logic               pix_sof_in,
  output logic               pix_ready_out,
  output logic [10:0]        lb_hcount_out,
  output logic [9:0]         lb_vcount_out,
  output logic [PIXEL_W-1:0] lb_pixel_out,
  output logic               lb_valid_out,
  input  logic               lb_valid_in,
  output logic               window_valid_out,
  output logic [1:0]         state_out,
  output logic               frame_done_out,
`ifdef LB_SEQ_STATS_EN
  output logic [15:0]        frame_count_out,
  output logic [15:0]        drop_count_out,
`endif
  output logic               err_sof_out
);

  localparam logic [10:0] HLast    = 11'(HRES - 1);
  localparam logic [9:0]  VLast    = 10'(VRES - 1);
  localparam logic [1:0]  PrimeMax = 2'(KERNEL_LINES - 1);

  seq_state_t         state_q, state_d;
  logic [10:0]        h_q, h_d, cur_h;
  logic [9:0]         v_q, v_d, cur_v;
  logic [1:0]         primed_q, primed_d, cur_primed;
  logic               lb_valid_q, lb_valid_d;
  logic [PIXEL_W-1:0] lb_pixel_q, lb_pixel_d;
  logic [10:0]        lb_h_q, lb_h_d;
  logic [9:0]         lb_v_q, lb_v_d;
  logic               lb_primed_q, lb_primed_d;
  logic               frame_done_q, frame_done_d;
  logic               err_sof_q, err_sof_d;
  logic               xfer, fwd, drop;
  logic               win_flag;

  assign pix_ready_out = (state_q != StGap);
  assign xfer          = pix_valid_in & pix_ready_out;

  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    v_d          = v_q;
    primed_d     = primed_q;
    lb_valid_d   = 1'b0;
    lb_pixel_d   = lb_pixel_q;
    lb_h_d       = lb_h_q;
    lb_v_d       = lb_v_q;
    lb_primed_d  = 1'b0;
    frame_done_d = 1'b0;
    err_sof_d    = 1'b0;
    fwd          = 1'b0;
    drop         = 1'b0;
    cur_h        = h_q;
    cur_v        = v_q;
    cur_primed   = primed_q;

    if (state_q == StGap) begin
      state_d = (primed_q < PrimeMax) ? StPrime : StRun;
    end else if (xfer) begin
      if (pix_sof_in) begin
        // SOF always restarts the raster, whether or not a frame was in flight.
        fwd        = 1'b1;
        cur_h      = '0;
        cur_v      = '0;
        cur_primed = '0;
        err_sof_d  = (state_q != StIdle);
        state_d    = StPrime;
      end else if (state_q != StIdle) begin
        fwd = 1'b1;
      end else begin
        drop = 1'b1;
      end

      if (fwd) begin
        lb_valid_d  = 1'b1;
        lb_pixel_d  = pix_data_in;
        lb_h_d      = cur_h;
        lb_v_d      = cur_v;
        lb_primed_d = (cur_primed == PrimeMax);
        if (cur_h == HLast) begin
          h_d = '0;
          if (cur_v == VLast) begin
            v_d          = '0;
            primed_d     = '0;
            frame_done_d = 1'b1;
            state_d      = StIdle;
          end else begin
            v_d      = cur_v + 10'd1;
            primed_d = (cur_primed == PrimeMax) ? cur_primed : cur_primed + 2'd1;
            state_d  = StGap;
          end
        end else begin
          h_d      = cur_h + 11'd1;
          v_d      = cur_v;
          primed_d = cur_primed;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      h_q          <= '0;
      v_q          <= '0;
      primed_q     <= '0;
      lb_valid_q   <= 1'b0;
      lb_pixel_q   <= '0;
      lb_h_q       <= '0;
      lb_v_q       <= '0;
      lb_primed_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_sof_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      v_q          <= v_d;
      primed_q     <= primed_d;
      lb_valid_q   <= lb_valid_d;
      lb_pixel_q   <= lb_pixel_d;
      lb_h_q       <= lb_h_d;
      lb_v_q       <= lb_v_d;
      lb_primed_q  <= lb_primed_d;
      frame_done_q <= frame_done_d;
      err_sof_q    <= err_sof_d;
    end
  end

  // Primed flag travels alongside the pixel through the line buffer's latency.
  lb_seq_delay #(
    .Stages (LB_LATENCY),
    .Width  (1)
  ) u_primed_dly (
    .clk_i (clk_in),
    .rst_i (rst_in),
    .d_i   (lb_primed_q),
    .q_o   (win_flag)
  );

  assign lb_valid_out     = lb_valid_q;
  assign lb_pixel_out     = lb_pixel_q;
  assign lb_hcount_out    = lb_h_q;
  assign lb_vcount_out    = lb_v_q;
  assign frame_done_out   = frame_done_q;
  assign err_sof_out      = err_sof_q;
  assign state_out        = state_q;
  assign window_valid_out = lb_valid_in & win_flag;

`ifdef LB_SEQ_STATS_EN
  logic [15:0] frame_count_q, frame_count_d;
  logic [15:0] drop_count_q, drop_count_d;

  always_comb begin
    frame_count_d = frame_count_q + (frame_done_d ? 16'd1 : 16'd0);
    drop_count_d  = drop_count_q;
    if (drop && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign frame_count_out = frame_count_q;
  assign drop_count_out  = drop_count_q;
`endif

endmodule

// File: tb/tb_line_buffer_sequencer.sv
// Randomized bench for line_buffer_sequencer on a 4x4 raster with a 2-cycle line-buffer model.
// Checks the optional statistics outputs when LB_SEQ_STATS_EN is defined.
module tb_line_buffer_sequencer;

  localparam int HRES = 4;
  localparam int VRES = 4;
  localparam int LAT  = 2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        pix_valid_in = 1'b0;
  logic [15:0] pix_data_in = '0;
  logic        pix_sof_in = 1'b0;
  logic        pix_ready_out;
  logic [10:0] lb_hcount_out;
  logic [9:0]  lb_vcount_out;
  logic [15:0] lb_pixel_out;
  logic        lb_valid_out;
  logic        lb_valid_in;
  logic        window_valid_out;
  logic [1:0]  state_out;
  logic        frame_done_out;
  logic        err_sof_out;
`ifdef LB_SEQ_STATS_EN
  logic [15:0] frame_count_out;
  logic [15:0] drop_count_out;
`endif

  line_buffer_sequencer #(
    .HRES       (HRES),
    .VRES       (VRES),
    .LB_LATENCY (LAT)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .pix_valid_in     (pix_valid_in),
    .pix_data_in      (pix_data_in),
    .pix_sof_in       (pix_sof_in),
    .pix_ready_out    (pix_ready_out),
    .lb_hcount_out    (lb_hcount_out),
    .lb_vcount_out    (lb_vcount_out),
    .lb_pixel_out     (lb_pixel_out),
    .lb_valid_out     (lb_valid_out),
    .lb_valid_in      (lb_valid_in),
    .window_valid_out (window_valid_out),
    .state_out        (state_out),
    .frame_done_out   (frame_done_out),
`ifdef LB_SEQ_STATS_EN
    .frame_count_out  (frame_count_out),
    .drop_count_out   (drop_count_out),
`endif
    .err_sof_out      (err_sof_out)
  );

  always #5 clk_in = ~clk_in;

  // Line buffer stand-in: data_valid follows lb_valid_out by LAT cycles.
  logic [LAT-1:0] lbv_sr = '0;
  always @(posedge clk_in) lbv_sr <= {lbv_sr[LAT-2:0], lb_valid_out};
  assign lb_valid_in = lbv_sr[LAT-1];

  int total = 0;
  int bad   = 0;

  // Reference model: raster position, completed lines in frame, gap pending.
  bit m_active, m_gap;
  int m_h, m_v, m_lines, m_frames, m_drops;
  bit hist [LAT+1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_state();
    if (!m_active) return 0;
    if (m_gap) return 3;
    return (m_lines >= 2) ? 2 : 1;
  endfunction

  task automatic model_reset();
    m_active = 0; m_gap = 0; m_h = 0; m_v = 0; m_lines = 0; m_frames = 0; m_drops = 0;
    for (int i = 0; i <= LAT; i++) hist[i] = 0;
  endtask

  // Called just after a rising edge: drive, advance model, clock, check.
  task automatic cycle(input logic v, input logic s, input logic [15:0] d, output logic took);
    bit fwd, fprim, done, err;
    int fh, fv;
    pix_valid_in = v; pix_sof_in = s; pix_data_in = d;
    #1;
    chk("ready", 32'(pix_ready_out), 32'(!m_gap));
    took = v && !m_gap;
    fwd = 0; fprim = 0; done = 0; err = 0; fh = 0; fv = 0;
    if (m_gap) begin
      m_gap = 0;
    end else if (took) begin
      if (s) begin
        err = m_active; m_active = 1; m_h = 0; m_v = 0; m_lines = 0;
      end
      if (!m_active) begin
        if (m_drops < 65535) m_drops++;
      end else begin
        fwd = 1; fh = m_h; fv = m_v; fprim = (m_lines >= 2);
        if (fh == HRES - 1) begin
          if (fv == VRES - 1) begin
            done = 1; m_active = 0; m_h = 0; m_v = 0; m_lines = 0; m_frames++;
          end else begin
            m_h = 0; m_v++; m_lines++; m_gap = 1;
          end
        end else begin
          m_h++;
        end
      end
    end
    for (int i = LAT; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = fwd && fprim;
    @(posedge clk_in);
    #1;
    chk("lb_valid", 32'(lb_valid_out), 32'(fwd));
    if (fwd) begin
      chk("hcount", 32'(lb_hcount_out), 32'(fh));
      chk("vcount", 32'(lb_vcount_out), 32'(fv));
      chk("pixel", 32'(lb_pixel_out), 32'(d));
    end
    chk("frame_done", 32'(frame_done_out), 32'(done));
    chk("err_sof", 32'(err_sof_out), 32'(err));
    chk("state", 32'(state_out), 32'(exp_state()));
    chk("window", 32'(window_valid_out), 32'(hist[LAT]));
`ifdef LB_SEQ_STATS_EN
    chk("frame_count", 32'(frame_count_out), 32'(m_frames & 16'hFFFF));
    chk("drop_count", 32'(drop_count_out), 32'(m_drops));
`endif
  endtask

  task automatic run_frame(input int npix, input bit bubbles, input bit sof_first,
                           output int lbv, output int fd);
    int sent, guard;
    logic took, v;
    sent = 0; guard = 0; lbv = 0; fd = 0;
    while (sent < npix && guard < 400) begin
      v = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle(v, sof_first && sent == 0, 16'($urandom), took);
      if (took) sent++;
      lbv += int'(lb_valid_out);
      fd += int'(frame_done_out);
      guard++;
    end
    chk("pixels_accepted", 32'(sent), 32'(npix));
    pix_valid_in = 1'b0;
    pix_sof_in = 1'b0;
  endtask

  // Entered just after a rising edge; asserts reset between edges.
  task automatic do_reset();
    #3;
    rst_in = 1'b1;
    #1;
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_lb_valid", 32'(lb_valid_out), 32'd0);
    chk("rst_outputs", 32'({lb_hcount_out, lb_vcount_out, lb_pixel_out, window_valid_out,
                            frame_done_out, err_sof_out}), 32'd0);
    chk("rst_ready", 32'(pix_ready_out), 32'd1);
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    pix_valid_in = 1'b0;
    pix_sof_in = 1'b0;
    model_reset();
  endtask

  initial begin
    int lbv, fd;
    logic took;
    model_reset();
    @(posedge clk_in);
    #1;
    do_reset();

    // Non-SOF pixels while idle are dropped.
    run_frame(5, 1'b0, 1'b0, lbv, fd);
    chk("idle_drop_lbv", 32'(lbv), 32'd0);

    // Continuous frame, then a frame with random bubbles.
    run_frame(16, 1'b0, 1'b1, lbv, fd);
    chk("frame1_lbv", 32'(lbv), 32'd16);
    chk("frame1_done", 32'(fd), 32'd1);
    run_frame(16, 1'b1, 1'b1, lbv, fd);
    chk("frame2_lbv", 32'(lbv), 32'd16);
    chk("frame2_done", 32'(fd), 32'd1);

    // Mid-frame SOF arriving at (2,1).
    run_frame(6, 1'b0, 1'b1, lbv, fd);
    cycle(1'b1, 1'b1, 16'hBEEF, took);
    chk("midsof_err", 32'(err_sof_out), 32'd1);
    chk("midsof_h", 32'(lb_hcount_out), 32'd0);
    chk("midsof_v", 32'(lb_vcount_out), 32'd0);
    chk("midsof_state", 32'(state_out), 32'd1);
    run_frame(15, 1'b1, 1'b0, lbv, fd);
    chk("midsof_done", 32'(fd), 32'd1);

    // SOF coincident with the end-of-line pixel: restart wins over GAP.
    run_frame(3, 1'b0, 1'b1, lbv, fd);
    cycle(1'b1, 1'b1, 16'h1234, took);
    chk("eolsof_state", 32'(state_out), 32'd1);
    chk("eolsof_ready", 32'(pix_ready_out), 32'd1);
    run_frame(15, 1'b1, 1'b0, lbv, fd);
    chk("eolsof_done", 32'(fd), 32'd1);

    // Reset mid-line discards the frame; block waits for the next SOF.
    run_frame(2, 1'b0, 1'b1, lbv, fd);
    cycle(1'b0, 1'b0, 16'h0, took);
    run_frame(1, 1'b0, 1'b0, lbv, fd);
    do_reset();
    run_frame(3, 1'b1, 1'b0, lbv, fd);
    chk("post_rst_drop", 32'(lbv), 32'd0);
    run_frame(16, 1'b1, 1'b1, lbv, fd);
    chk("post_rst_lbv", 32'(lbv), 32'd16);
    chk("post_rst_done", 32'(fd), 32'd1);

    repeat (4) cycle(1'b0, 1'b0, 16'h0, took);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
